// File: rtl/mem_pkg.sv
// Shared constants and types for the 16-bit memory responder.
// State encoding, counter width and default bus widths.
package mem_pkg;

    localparam int defDataW = 16;
    localparam int defAddrW = 16;
    localparam int cntW     = 4;

    localparam logic [1:0] stIdle = 2'd0;
    localparam logic [1:0] stWait = 2'd1;
    localparam logic [1:0] stResp = 2'd2;

    typedef enum logic [1:0] {
        IDLE = stIdle,
        WAIT = stWait,
        RESP = stResp
    } state_t;

endpackage

// File: rtl/mem_array_16.sv
// Word storage: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module mem_array_16
    import mem_pkg::*;
#(
    parameter int DATA_W     = defDataW,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  wrEn,
    input  logic [DEPTH_LOG2-1:0] wrIdx,
    input  logic [DATA_W-1:0]     wrData,
    input  logic [DEPTH_LOG2-1:0] rdIdx,
    output logic [DATA_W-1:0]     rdData
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrIdx] <= wrData;
        end
    end

    assign rdData = mem[rdIdx];

endmodule

// File: rtl/mem_responder_16.sv
// Fixed-latency memory responder for pipeline memory-stage requests.
// One word read/write per request; odd byte addresses report an error.
module mem_responder_16
    import mem_pkg::*;
#(
    parameter int DATA_W     = defDataW,
    parameter int ADDR_W     = defAddrW,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam logic [cntW-1:0] cntLoad = cntW'(LATENCY - 1);

    state_t state;
    state_t nextState;

    logic [cntW-1:0]     cnt;
    logic                started;
    logic                accept;
    logic                enterResp;
    logic                latWr;
    logic [DEPTH_LOG2:0] latAddr;
    logic [DATA_W-1:0]   latData;
    logic                curWr;
    logic [DEPTH_LOG2:0] curAddr;
    logic [DATA_W-1:0]   curData;
    logic [DATA_W-1:0]   rdData;
    logic                unusedAddrBits;

    assign unusedAddrBits = ^req_addr[ADDR_W-1:DEPTH_LOG2+1];

    assign req_ready  = started && (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (accept) nextState = (LATENCY == 1) ? RESP : WAIT;
            WAIT: if (cnt == cntW'(1)) nextState = RESP;
            RESP: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign enterResp = (nextState == RESP) && (state != RESP);

    // A single-cycle build enters RESP straight from IDLE, before the latch
    assign curWr   = (state == IDLE) ? req_wr : latWr;
    assign curAddr = (state == IDLE) ? req_addr[DEPTH_LOG2:0] : latAddr;
    assign curData = (state == IDLE) ? req_wdata : latData;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            started <= 1'b0;
            cnt     <= '0;
            latWr   <= 1'b0;
            latAddr <= '0;
            latData <= '0;
        end else begin
            state   <= nextState;
            started <= 1'b1;
            if (accept) begin
                cnt     <= cntLoad;
                latWr   <= req_wr;
                latAddr <= req_addr[DEPTH_LOG2:0];
                latData <= req_wdata;
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else if (enterResp) begin
            resp_err   <= curAddr[0];
            resp_rdata <= curAddr[0] ? '0 : (curWr ? curData : rdData);
        end
    end

    mem_array_16 #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) uArray (
        .clk    (clk),
        .wrEn   (enterResp && curWr && !curAddr[0]),
        .wrIdx  (curAddr[DEPTH_LOG2:1]),
        .wrData (curData),
        .rdIdx  (curAddr[DEPTH_LOG2:1]),
        .rdData (rdData)
    );

endmodule

// File: tb/tb_mem_responder_16.sv
// Bench for mem_responder_16: a LATENCY=4 and a LATENCY=1 instance
// checked every cycle against a transaction-level model.
module tb_mem_responder_16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        reqValid [2];
    logic        reqWr [2];
    logic [15:0] reqAddr [2];
    logic [15:0] reqWdata [2];
    logic [1:0]  reqReady;
    logic [1:0]  respValid;
    logic [1:0]  respErr;
    logic [1:0]  busy;
    logic [15:0] respRdata [2];

    int nErr = 0;
    int nChk = 0;

    always #5 clk = ~clk;

    mem_responder_16 #(.LATENCY(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]),
        .req_wr(reqWr[0]), .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
        .resp_valid(respValid[0]), .resp_rdata(respRdata[0]),
        .resp_err(respErr[0]), .busy(busy[0])
    );

    mem_responder_16 #(.LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]),
        .req_wr(reqWr[1]), .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
        .resp_valid(respValid[1]), .resp_rdata(respRdata[1]),
        .resp_err(respErr[1]), .busy(busy[1])
    );

    task automatic chk(input string nm, input int i,
                       input logic [15:0] act, input logic [15:0] exp);
        nChk++;
        if (act !== exp) begin
            nErr++;
            if (nErr <= 40)
                $display("FAIL %s[dut%0d] got=%h want=%h t=%0t",
                         nm, i, act, exp, $time);
        end
    endtask

    // Transaction-level model: cycle numbers of accept/response, word memory
    int          lat [2] = '{4, 1};
    int          p = 0;
    bit          pend [2];
    int          acc [2];
    bit          pWr [2];
    logic [15:0] pAddr [2];
    logic [15:0] pData [2];
    bit          eReady [2];
    bit          eValid [2];
    bit          eBusy [2];
    bit          eErr [2];
    bit          eKnown [2] = '{1'b1, 1'b1};
    logic [15:0] eRdata [2] = '{16'h0, 16'h0};
    logic [15:0] mMem [2][256];
    bit          mKnown [2][256];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    pend[i] = 0; eReady[i] = 0; eValid[i] = 0;
                    eBusy[i] = 0; eErr[i] = 0; eRdata[i] = 16'h0;
                    eKnown[i] = 1;
                end
            end else begin
                p++;
                for (int i = 0; i < 2; i++) begin
                    bit take;
                    int w;
                    take = eReady[i] && reqValid[i];
                    if (pend[i] && p == acc[i] + lat[i]) pend[i] = 0;
                    if (take) begin
                        pend[i] = 1; acc[i] = p;
                        pWr[i] = reqWr[i]; pAddr[i] = reqAddr[i];
                        pData[i] = reqWdata[i];
                    end
                    eValid[i] = 0;
                    if (pend[i] && p == acc[i] + lat[i] - 1) begin
                        eValid[i] = 1;
                        w = int'(pAddr[i][8:1]);
                        if (pAddr[i][0]) begin
                            eErr[i] = 1; eRdata[i] = 16'h0; eKnown[i] = 1;
                        end else if (pWr[i]) begin
                            mMem[i][w] = pData[i]; mKnown[i][w] = 1;
                            eErr[i] = 0; eRdata[i] = pData[i]; eKnown[i] = 1;
                        end else begin
                            eErr[i] = 0; eRdata[i] = mMem[i][w];
                            eKnown[i] = mKnown[i][w];
                        end
                    end
                    eBusy[i] = pend[i];
                    eReady[i] = !pend[i];
                end
            end
        end
    end

    initial begin
        #3;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("req_ready", i, 16'(reqReady[i]), 16'(eReady[i]));
                chk("resp_valid", i, 16'(respValid[i]), 16'(eValid[i]));
                chk("busy", i, 16'(busy[i]), 16'(eBusy[i]));
                chk("resp_err", i, 16'(respErr[i]), 16'(eErr[i]));
                if (eKnown[i]) chk("resp_rdata", i, respRdata[i], eRdata[i]);
            end
        end
    end

    task automatic doReq(input int i, input bit wr, input logic [15:0] a,
                         input logic [15:0] d, output logic [15:0] rd,
                         output logic er, output int n);
        bit got;
        @(negedge clk);
        reqValid[i] = 1'b1; reqWr[i] = wr; reqAddr[i] = a; reqWdata[i] = d;
        got = 0;
        for (int k = 0; k < 50; k++) begin
            if (reqReady[i]) begin got = 1; break; end
            @(negedge clk);
        end
        rd = 16'h0; er = 1'b0; n = -1;
        if (!got) begin
            chk("acceptTimeout", i, 16'd0, 16'd1);
            reqValid[i] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 reqValid[i] = 1'b0;
        n = 0; got = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            n++;
            if (respValid[i]) begin got = 1; break; end
        end
        if (!got) chk("respTimeout", i, 16'd0, 16'd1);
        rd = respRdata[i];
        er = respErr[i];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic        er;
        int          n;
        int          last;
        int          nAcc;
        int          nResp;

        for (int i = 0; i < 2; i++) begin
            reqValid[i] = 0; reqWr[i] = 0; reqAddr[i] = 0; reqWdata[i] = 0;
        end
        #2 rst_n = 1'b0;

        // 1: reset and idle
        repeat (3) @(negedge clk);
        chk("readyInReset", 0, 16'(reqReady[0]), 16'd0);
        chk("busyInReset", 0, 16'(busy[0]), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("readyAfterRelease", 0, 16'(reqReady[0]), 16'd1);
        chk("readyAfterRelease", 1, 16'(reqReady[1]), 16'd1);
        repeat (3) @(negedge clk);

        // 2: write then read back
        doReq(0, 1'b1, 16'h0010, 16'hBEEF, rd, er, n);
        chk("wrLatency", 0, 16'(n), 16'd4);
        chk("wrEcho", 0, rd, 16'hBEEF);
        doReq(0, 1'b0, 16'h0010, 16'h0000, rd, er, n);
        chk("rdLatency", 0, 16'(n), 16'd4);
        chk("rdData", 0, rd, 16'hBEEF);
        chk("rdErr", 0, 16'(er), 16'd0);

        // 3: misaligned read, then no corruption
        doReq(0, 1'b0, 16'h0011, 16'h0000, rd, er, n);
        chk("oddErr", 0, 16'(er), 16'd1);
        chk("oddData", 0, rd, 16'h0000);
        chk("oddLatency", 0, 16'(n), 16'd4);
        doReq(0, 1'b1, 16'h0013, 16'h7777, rd, er, n);
        chk("oddWrErr", 0, 16'(er), 16'd1);
        doReq(0, 1'b0, 16'h0010, 16'h0000, rd, er, n);
        chk("rdAfterOdd", 0, rd, 16'hBEEF);

        // 4: valid held high
        @(negedge clk);
        reqValid[0] = 1'b1; reqWr[0] = 1'b0; reqAddr[0] = 16'h0010;
        last = -1; nAcc = 0;
        for (int k = 0; k < 24; k++) begin
            if (reqReady[0]) begin
                if (last >= 0) chk("acceptGap", 0, 16'(k - last), 16'd5);
                last = k;
                nAcc++;
            end
            @(negedge clk);
        end
        reqValid[0] = 1'b0;
        chk("acceptCount", 0, 16'(nAcc), 16'd5);
        repeat (8) @(negedge clk);

        // 5: reset during WAIT drops the write
        @(negedge clk);
        reqValid[0] = 1'b1; reqWr[0] = 1'b1;
        reqAddr[0] = 16'h0020; reqWdata[0] = 16'h1234;
        @(posedge clk);
        #1 reqValid[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("busyBeforeReset", 0, 16'(busy[0]), 16'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nResp = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (respValid[0]) nResp++;
        end
        chk("noRespAfterReset", 0, 16'(nResp), 16'd0);
        doReq(0, 1'b1, 16'h0020, 16'h5555, rd, er, n);
        doReq(0, 1'b0, 16'h0020, 16'h0000, rd, er, n);
        chk("rewriteData", 0, rd, 16'h5555);

        // 6: LATENCY=1 instance with address aliasing
        doReq(1, 1'b1, 16'h0202, 16'hA5A5, rd, er, n);
        chk("l1WrLatency", 1, 16'(n), 16'd1);
        doReq(1, 1'b0, 16'h0002, 16'h0000, rd, er, n);
        chk("l1RdLatency", 1, 16'(n), 16'd1);
        chk("aliasData", 1, rd, 16'hA5A5);
        chk("aliasErr", 1, 16'(er), 16'd0);
        doReq(1, 1'b0, 16'h0003, 16'h0000, rd, er, n);
        chk("l1OddErr", 1, 16'(er), 16'd1);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end

endmodule
